instr_mem_responder: RTL and testbench

Memory-side responder for the instruction fetch request interface: it grants fetch requests, reads a word-addressed instruction array and returns in-order responses after a fixed, parameterised latency. It sits between the fetch stage (initiator) and the instruction storage and replaces the zero-wait memory model. This lets the pipeline be exercised against realistic multi-cycle instruction memory and flush-cancelled fetches.

---
 rtl/instr_mem_responder_pkg.sv | 19 +
 rtl/instr_mem_responder_delay_line.sv | 49 ++++
 rtl/instr_mem_responder.sv | 97 +++++++++
 tb/tb_instr_mem_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_responder_pkg.sv
// Shared types and default constants for the instruction-memory responder.
// Build option IMEM_BOUNDS_CHECK_EN (see instr_mem_responder) changes only the top.
package instr_mem_responder_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } imem_rsp_t;

  localparam int IMEM_DEPTH_WORDS     = 1024;
  localparam int IMEM_LATENCY         = 2;
  localparam int IMEM_MAX_OUTSTANDING = 2;
  localparam int IMEM_MAX_LATENCY     = 8;

  // Wide enough to hold any legal outstanding count (0..IMEM_MAX_LATENCY).
  localparam int IMEM_CNT_W = $clog2(IMEM_MAX_LATENCY + 1);

endpackage

// File: rtl/instr_mem_responder_delay_line.sv
// LATENCY-stage shift register of responses; reset and flush clear only valid bits,
// the payload just follows the valid bits down the line.
module imem_delay_line
  import instr_mem_responder_pkg::*;
#(
  parameter int LATENCY = IMEM_LATENCY
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      flush,
  input  imem_rsp_t rsp_in,
  output imem_rsp_t rsp_out
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [31:0]        data_q [LATENCY];
  logic [31:0]        data_d [LATENCY];

  always_comb begin
    vld_d     = vld_q;
    err_d     = err_q;
    data_d    = data_q;
    vld_d[0]  = rsp_in.valid;
    err_d[0]  = rsp_in.err;
    data_d[0] = rsp_in.data;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      err_d[i]  = err_q[i-1];
      data_d[i] = data_q[i-1];
    end
    if (flush) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    err_q  <= err_d;
    data_q <= data_d;
  end

  assign rsp_out = '{valid: vld_q[LATENCY-1], err: err_q[LATENCY-1], data: data_q[LATENCY-1]};

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: grants fetches, returns in-order responses after LATENCY cycles.
// Define IMEM_BOUNDS_CHECK_EN to flag misaligned / out-of-range fetches with instr_err_op.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS     = IMEM_DEPTH_WORDS,
  parameter int LATENCY         = IMEM_LATENCY,
  parameter int MAX_OUTSTANDING = IMEM_MAX_OUTSTANDING
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_en,
  input  logic        instr_req_ip,
  input  logic [31:0] instr_addr_ip,
  input  logic        flush_ip,
  output logic        instr_gnt_op,
  output logic        instr_valid_op,
  output logic [31:0] instr_data_op,
  output logic        instr_err_op,
  input  logic        load_we_ip,
  input  logic [31:0] load_addr_ip,
  input  logic [31:0] load_data_ip
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [IMEM_CNT_W-1:0] MAX_OUT_C = IMEM_CNT_W'(MAX_OUTSTANDING);

  logic [31:0]           mem_q [DEPTH_WORDS];
  logic [AW-1:0]         rd_idx;
  logic [AW-1:0]         wr_idx;
  logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic                  gnt;
  logic                  addr_err;
  imem_rsp_t             rsp_in;
  imem_rsp_t             rsp_out;

  assign rd_idx = instr_addr_ip[AW+1:2];
  assign wr_idx = load_addr_ip[AW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic unused_addr_bits;
  assign addr_err         = (instr_addr_ip[1:0] != 2'b00) || (instr_addr_ip[31:AW+2] != '0);
  assign unused_addr_bits = ^{load_addr_ip[31:AW+2], load_addr_ip[1:0]};
`else
  logic unused_addr_bits;
  assign addr_err         = 1'b0;
  assign unused_addr_bits = ^{load_addr_ip[31:AW+2], load_addr_ip[1:0],
                              instr_addr_ip[31:AW+2], instr_addr_ip[1:0]};
`endif

  // Grant is held off during reset so nothing enters the line while it is being cleared.
  assign gnt = reset & instr_req_ip & mem_en & ~flush_ip & (cnt_q < MAX_OUT_C);

  // Asynchronous read against a clocked write gives read-before-write on a collision.
  always_comb begin
    rsp_in.valid = gnt;
    rsp_in.err   = addr_err;
    rsp_in.data  = addr_err ? 32'h0 : mem_q[rd_idx];
  end

  always_ff @(posedge clock) begin
    if (load_we_ip) begin
      mem_q[wr_idx] <= load_data_ip;
    end
  end

  always_comb begin
    cnt_d = cnt_q + IMEM_CNT_W'(gnt) - IMEM_CNT_W'(rsp_out.valid);
    if (flush_ip) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  imem_delay_line #(
    .LATENCY (LATENCY)
  ) u_delay_line (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush_ip),
    .rsp_in  (rsp_in),
    .rsp_out (rsp_out)
  );

  assign instr_gnt_op   = gnt;
  assign instr_valid_op = reset & rsp_out.valid;
  assign instr_err_op   = instr_valid_op & rsp_out.err;
  assign instr_data_op  = instr_valid_op ? rsp_out.data : 32'h0;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two configurations share one stimulus stream and are
// checked every cycle against a scheduled-response reference model.
module tb_instr_mem_responder;

  localparam int DA = 1024;
  localparam int LA = 2;
  localparam int MA = 2;
  localparam int DB = 64;
  localparam int LB = 3;
  localparam int MB = 1;

  logic        clock = 1'b0;
  logic        reset, mem_en, req, flush, load_we;
  logic [31:0] addr, load_addr, load_data;
  logic        gnt_a, vld_a, err_a, gnt_b, vld_b, err_b;
  logic [31:0] data_a, data_b;

  always #5 clock = ~clock;

  instr_mem_responder #(.DEPTH_WORDS(DA), .LATENCY(LA), .MAX_OUTSTANDING(MA)) dut_a (
    .clock(clock), .reset(reset), .mem_en(mem_en), .instr_req_ip(req), .instr_addr_ip(addr),
    .flush_ip(flush), .instr_gnt_op(gnt_a), .instr_valid_op(vld_a), .instr_data_op(data_a),
    .instr_err_op(err_a), .load_we_ip(load_we), .load_addr_ip(load_addr), .load_data_ip(load_data));

  instr_mem_responder #(.DEPTH_WORDS(DB), .LATENCY(LB), .MAX_OUTSTANDING(MB)) dut_b (
    .clock(clock), .reset(reset), .mem_en(mem_en), .instr_req_ip(req), .instr_addr_ip(addr),
    .flush_ip(flush), .instr_gnt_op(gnt_b), .instr_valid_op(vld_b), .instr_data_op(data_b),
    .instr_err_op(err_b), .load_we_ip(load_we), .load_addr_ip(load_addr), .load_data_ip(load_data));

  // Reference state: word arrays plus a table of responses keyed by the cycle they are due.
  logic [31:0] mem_m [2][DA];
  logic        pv [2][16];
  logic [31:0] pd [2][16];
  logic        pe [2][16];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic addr_err(input logic [31:0] a, input int dep);
`ifdef IMEM_BOUNDS_CHECK_EN
    return (a % 4 != 0) || (longint'(a) >= longint'(4 * dep));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int word_idx(input logic [31:0] a, input int dep);
    logic [31:0] w;
    w = a / 4;
    return int'(w % 32'(dep));
  endfunction

  // One clock: compare at the falling edge, advance the model, then release to the next cycle.
  task automatic tick();
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      int          lat, mo, dep, slot, outst;
      logic        ev, eg, ee, og, ov, oe, er;
      logic [31:0] ed, od;
      lat   = (k == 0) ? LA : LB;
      mo    = (k == 0) ? MA : MB;
      dep   = (k == 0) ? DA : DB;
      slot  = cyc % 16;
      outst = 0;
      for (int s = 0; s < 16; s++) outst += pv[k][s] ? 1 : 0;
      ev = reset && pv[k][slot];
      ed = ev ? pd[k][slot] : 32'h0;
      ee = ev ? pe[k][slot] : 1'b0;
      eg = reset && req && mem_en && !flush && (outst < mo);
      og = (k == 0) ? gnt_a : gnt_b;
      ov = (k == 0) ? vld_a : vld_b;
      oe = (k == 0) ? err_a : err_b;
      od = (k == 0) ? data_a : data_b;
      check($sformatf("gnt%0d", k), 32'(og), 32'(eg));
      check($sformatf("valid%0d", k), 32'(ov), 32'(ev));
      check($sformatf("data%0d", k), od, ed);
      check($sformatf("err%0d", k), 32'(oe), 32'(ee));
      pv[k][slot] = 1'b0;
      if (!reset || flush) begin
        for (int s = 0; s < 16; s++) pv[k][s] = 1'b0;
      end else if (eg) begin
        er = addr_err(addr, dep);
        pv[k][(cyc + lat) % 16] = 1'b1;
        pe[k][(cyc + lat) % 16] = er;
        pd[k][(cyc + lat) % 16] = er ? 32'h0 : mem_m[k][word_idx(addr, dep)];
      end
      if (load_we) mem_m[k][word_idx(load_addr, dep)] = load_data;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    reset = 1'b1; mem_en = 1'b1; req = 1'b0; flush = 1'b0; load_we = 1'b0;
  endtask

  task automatic idle(input int n);
    quiet();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fetch(input logic [31:0] a);
    quiet();
    req = 1'b1; addr = a;
    tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 16; s++) begin
        pv[k][s] = 1'b0; pd[k][s] = '0; pe[k][s] = 1'b0;
      end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DA; i++) mem_m[k][i] = 'x;
    reset = 1'b0; mem_en = 1'b1; req = 1'b1; flush = 1'b0; load_we = 1'b0;
    addr = 32'h0; load_addr = 32'h0; load_data = 32'h0;
    @(posedge clock);
    #1;

    // Reset held with a request pending: no grant, all outputs zero.
    for (int i = 0; i < 3; i++) tick();

    // Preload from the top down so the low words win in the smaller aliased array.
    quiet();
    for (int i = DA - 1; i >= 0; i--) begin
      load_we = 1'b1; load_addr = 32'(i * 4);
      load_data = (i == 4) ? 32'h0050_0093 : $urandom;
      tick();
    end

    fetch(32'h10);
    idle(4);
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
    idle(4);
    for (int i = 0; i < 8; i++) fetch(32'h20);
    idle(4);

    // Flush with two in flight and a concurrent request, then a normal fetch.
    fetch(32'h30); fetch(32'h34);
    quiet(); req = 1'b1; addr = 32'h38; flush = 1'b1; tick();
    fetch(32'h3C);
    idle(5);

    fetch(32'(4 * DA + 32'h10)); fetch(32'h12); fetch(32'(4 * DA));
    idle(5);

    quiet(); mem_en = 1'b0; req = 1'b1; addr = 32'h40;
    for (int i = 0; i < 3; i++) tick();
    idle(4);

    // Reset while a response is in flight, then a fetch right after release.
    fetch(32'h40);
    quiet(); reset = 1'b0; req = 1'b1; tick();
    quiet(); reset = 1'b0; tick();
    fetch(32'h44);
    idle(4);

    // Preload and fetch to the same word in one cycle: old data first, new data next.
    quiet(); req = 1'b1; addr = 32'h50; load_we = 1'b1; load_addr = 32'h50; load_data = 32'hCAFE_F00D;
    tick();
    fetch(32'h50);
    idle(4);

    for (int i = 0; i < 800; i++) begin
      int r;
      quiet();
      reset  = ($urandom_range(0, 49) != 0);
      flush  = ($urandom_range(0, 11) == 0);
      mem_en = ($urandom_range(0, 7) != 0);
      req    = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)       addr = {20'h0, 10'($urandom_range(0, DA - 1)), 2'b00};
      else if (r == 7) addr = 32'($urandom_range(0, 4 * DA - 1)) | 32'h1;
      else if (r == 8) addr = 32'(4 * DA) + 32'($urandom_range(0, 255) * 4);
      else             addr = $urandom;
      load_we   = ($urandom_range(0, 9) == 0);
      load_addr = 32'($urandom_range(0, 4 * DA - 1));
      load_data = $urandom;
      tick();
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
